// File: rtl/signed_mac_accumulator_9_pkg.sv
// ----------------------------------------------------------------------------
// signed_mac_accumulator_9_pkg : shared types and constants (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package signed_mac_accumulator_9_pkg;

  localparam int DEF_WIDTH = 9;
  localparam int DEF_ACC_W = 24;
  localparam int CNT_W     = 7;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/signed_mac_accumulator_9_mult.sv
// ----------------------------------------------------------------------------
// signed_parallel_multiplier_9_PPA_Kogge_Stone : carry-save signed array + KS adder (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module signed_parallel_multiplier_9_PPA_Kogge_Stone #(
  parameter int width = 9
) (
  input  logic [width-1:0]   A,
  input  logic [width-1:0]   B,
  output logic [2*width-1:0] S
);

  localparam int N = 2 * width;

  logic [N-1:0] a_ext;
  logic [N-1:0] row;
  logic [N-1:0] sum_v;
  logic [N-1:0] car_v;
  logic [N-1:0] t;
  logic [N-1:0] g;
  logic [N-1:0] p;

  always_comb begin
    a_ext = {{width{A[width-1]}}, A};
    sum_v = B[0] ? a_ext : '0;
    // The sign row of B is subtracted: invert here, the +1 rides in the carry vector.
    car_v = {{(N-1){1'b0}}, B[width-1]};
    row   = '0;
    t     = '0;
    for (int i = 1; i < width; i++) begin
      row = B[i] ? (a_ext << i) : '0;
      if (i == width - 1) row = B[i] ? ~(a_ext << i) : '0;
      t     = sum_v ^ car_v ^ row;
      car_v = ((sum_v & car_v) | (sum_v & row) | (car_v & row)) << 1;
      sum_v = t;
    end

    g = sum_v & car_v;
    p = sum_v ^ car_v;
    for (int d = 1; d < N; d = d * 2) begin
      g = g | (p & (g << d));
      p = p & (p << d);
    end
    S = sum_v ^ car_v ^ (g << 1);
  end

endmodule

`default_nettype wire

// File: rtl/signed_mac_accumulator_9.sv
// ----------------------------------------------------------------------------
// signed_mac_accumulator_9 : framed signed multiply-accumulate, 3-edge pipeline (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module signed_mac_accumulator_9
  import signed_mac_accumulator_9_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int               PW      = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic               accept;
  logic               first_beat;
  logic               s1_valid, s1_last, s1_first;
  logic [WIDTH-1:0]   s1_a, s1_b;
  logic               s2_valid, s2_last, s2_first;
  logic [PW-1:0]      s2_prod;
  logic [PW-1:0]      prod;
  logic [ACC_W-1:0]   acc, acc_base, acc_next, prod_ext;
  logic [CNT_W-1:0]   count, count_next;
  logic               ovf, ovf_step, ovf_next;

  assign accept = in_valid & in_ready;

  signed_parallel_multiplier_9_PPA_Kogge_Stone #(
    .width (WIDTH)
  ) u_mult (
    .A (s1_a),
    .B (s1_b),
    .S (prod)
  );

  always_comb begin
    prod_ext   = {{(ACC_W-PW){s2_prod[PW-1]}}, s2_prod};
    acc_base   = s2_first ? '0 : acc;
    acc_next   = acc_base + prod_ext;
    ovf_step   = (acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                 (acc_next[ACC_W-1] != acc_base[ACC_W-1]);
    ovf_next   = (!s2_first && ovf) || ovf_step;
    count_next = s2_first ? CNT_W'(1)
               : ((count == CNT_MAX) ? count : count + CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_beat <= 1'b1;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_first   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      s2_first   <= 1'b0;
      s2_prod    <= '0;
      acc        <= '0;
      count      <= '0;
      ovf        <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a       <= in_a;
        s1_b       <= in_b;
        s1_last    <= in_last;
        s1_first   <= first_beat;
        first_beat <= in_last;
      end
      s2_valid <= s1_valid;
      s2_last  <= s1_valid & s1_last;
      s2_first <= s1_first;
      s2_prod  <= prod;
      if (s2_valid) begin
        acc   <= acc_next;
        count <= count_next;
        ovf   <= ovf_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept && in_last) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (s2_valid && s2_last) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_sum   <= acc_next;
            out_count <= count_next;
            out_ovf   <= ovf_next;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_signed_mac_accumulator_9.sv
// ----------------------------------------------------------------------------
// tb_signed_mac_accumulator_9 : scoreboard bench with arithmetic reference model (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_signed_mac_accumulator_9;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [8:0]  in_a, in_b;
  logic        out_valid, out_ready, out_ovf;
  logic [23:0] out_sum;
  logic [6:0]  out_count;

  typedef struct packed {
    logic [23:0] sum;
    logic [6:0]  count;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 1;
  int   beat_a[128];
  int   beat_b[128];

  always #5 clk = ~clk;

  signed_mac_accumulator_9 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact running sum, overflow whenever it leaves the 24-bit signed range.
  task automatic model_push(input int n);
    longint      acc;
    longint      t;
    bit          ovf;
    logic [23:0] w;
    exp_t        e;
    acc = 0;
    ovf = 0;
    for (int i = 0; i < n; i++) begin
      t = acc + longint'(beat_a[i]) * longint'(beat_b[i]);
      if (t > 64'sd8388607 || t < -64'sd8388608) ovf = 1;
      w   = t[23:0];
      acc = longint'($signed(w));
    end
    e.sum   = acc[23:0];
    e.count = (n > 127) ? 7'd127 : 7'(n);
    e.ovf   = ovf;
    sbq.push_back(e);
  endtask

  task automatic send_beat(input int a, input int b, input bit last, output bit ok);
    int waited;
    waited   = 0;
    ok       = 0;
    in_valid = 1'b1;
    in_a     = a[8:0];
    in_b     = b[8:0];
    in_last  = last;
    while (waited < 1000) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      waited++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 for 1000 cycles expected acceptance");
    end
  endtask

  task automatic send_frame(input int n, input bit gaps);
    bit ok;
    model_push(n);
    for (int i = 0; i < n; i++) begin
      send_beat(beat_a[i], beat_b[i], i == n - 1, ok);
      if (!ok) return;
      if (gaps && i < n - 1 && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (sbq.size() != 0 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", sbq.size());
    end
  endtask

  // out_ready driver: 0 = held low, 1 = held high, 2 = random backpressure.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      out_ready = 1'b0;
      else if (rdy_mode == 1) out_ready = 1'b1;
      else                    out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every presented result must match the oldest expectation until it is taken.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got sum=%0d count=%0d with no frame pending",
                   $signed(out_sum), out_count);
        end else begin
          check("out_sum", longint'($signed(out_sum)), longint'($signed(sbq[0].sum)));
          check("out_count", longint'(out_count), longint'(sbq[0].count));
          check("out_ovf", longint'(out_ovf), longint'(sbq[0].ovf));
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    int  n;
    int  cyc;
    bit  ok;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", longint'(in_ready), 1);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_sum", longint'(out_sum), 0);
    check("reset_out_count", longint'(out_count), 0);
    check("reset_out_ovf", longint'(out_ovf), 0);
    @(posedge clk);
    #1;

    // Three-beat frame with latency check on out_valid.
    beat_a[0] = 3;  beat_b[0] = 4;
    beat_a[1] = -5; beat_b[1] = 6;
    beat_a[2] = 7;  beat_b[2] = -8;
    send_frame(3, 0);
    @(negedge clk);
    check("latency_e0", longint'(out_valid), 0);
    @(negedge clk);
    check("latency_e1", longint'(out_valid), 0);
    @(negedge clk);
    check("latency_e2", longint'(out_valid), 1);
    wait_idle();

    // Single-beat frame at the most negative operands.
    beat_a[0] = -256; beat_b[0] = -256;
    send_frame(1, 0);
    wait_idle();

    // 128 beats: wraps to -2^23, sticky overflow, saturated count.
    for (int i = 0; i < 128; i++) begin
      beat_a[i] = -256;
      beat_b[i] = -256;
    end
    send_frame(128, 0);
    wait_idle();

    // Backpressure: result held 5 cycles, then handshake and immediate next frame.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    beat_a[0] = 5; beat_b[0] = 5;
    beat_a[1] = 1; beat_b[1] = -1;
    send_frame(2, 0);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      if (out_valid) break;
      cyc++;
    end
    check("hold_out_valid_seen", longint'(out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      check("hold_in_ready", longint'(in_ready), 0);
      check("hold_out_valid", longint'(out_valid), 1);
    end
    rdy_mode = 1;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      if (!out_valid) break;
      cyc++;
    end
    check("release_out_valid", longint'(out_valid), 0);
    check("release_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    beat_a[0] = 2; beat_b[0] = 3;
    send_frame(1, 0);
    wait_idle();

    // Reset mid-frame discards the partial frame.
    send_beat(3, 3, 0, ok);
    send_beat(4, 4, 0, ok);
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_out_sum", longint'(out_sum), 0);
    check("midrst_out_count", longint'(out_count), 0);
    check("midrst_out_ovf", longint'(out_ovf), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat_a[0] = 2; beat_b[0] = 2;
    send_frame(1, 0);
    wait_idle();

    // Random frames with gaps and random backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 200; f++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        beat_a[i] = int'($urandom_range(0, 511)) - 256;
        beat_b[i] = int'($urandom_range(0, 511)) - 256;
      end
      send_frame(n, 1);
    end
    rdy_mode = 1;
    wait_idle();
    repeat (3) @(negedge clk);
    check("final_out_valid", longint'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/signed_mac_accumulator_9.md
SIGNED_MAC_ACCUMULATOR_9 -- requirements
Module: signed_mac_accumulator_9

Interface
REQ-001 Parameter: WIDTH, 9, operand width in bits, two's complement.
REQ-002 Parameter: ACC_W, 24, accumulator and result width in bits, two's complement.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operand beat valid.
REQ-006 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-007 Port: in_a, in_b  input  WIDTH each  signed operands.
REQ-008 Port: in_last  input  1  final beat of frame.
REQ-009 Port: out_valid  output  1  frame result valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: out_sum  output  ACC_W  signed sum of frame products.
REQ-012 Port: out_count  output  7  beats in frame, saturating at 127.
REQ-013 Port: out_ovf  output  1  accumulator signed overflow occurred in frame.

Function
REQ-014 Beat accepted on edge where in_valid and in_ready are both 1; in_ready has no combinational dependence on in_valid.
REQ-015 Stage 1 registers in_a, in_b, in_last, valid on acceptance edge E0.
REQ-016 Stage 2 feeds stage-1 operands to the combinational multiplier; full 2*WIDTH-bit signed product registered on E0+1.
REQ-017 Accumulate stage on E0+2: acc = (first beat of frame ? 0 : acc) + product sign-extended to ACC_W.
REQ-018 On last beat, out_sum, out_count, out_ovf load on E0+2 and out_valid rises; last-beat latency is exactly 3 edges.
REQ-019 FSM states: ACCUM (in_ready=1), DRAIN (in_ready=0, pipeline emptying), HOLD (in_ready=0, out_valid=1).
REQ-020 ACCUM -> DRAIN on acceptance of beat with in_last=1; DRAIN -> HOLD on the edge loading the result; HOLD -> ACCUM on edge with out_valid and out_ready both 1.
REQ-021 out_sum, out_count, out_ovf stable while out_valid=1 and out_ready=0.
REQ-022 out_valid falls on handshake edge; in_ready is 1 in the following cycle.
REQ-023 Non-last beats accepted back-to-back, one per cycle, in ACCUM.
REQ-024 Signed overflow in accumulation sets sticky ovf for the frame; sum wraps modulo 2^ACC_W; ovf clears at frame start.
REQ-025 Beat counter increments per accepted beat, saturates at 127, clears at frame start.
REQ-026 Single-beat frame (in_last on first beat) valid: out_sum = product, out_count = 1.
REQ-027 in_valid=0 gaps within a frame do not alter acc, count or state.

Reset
REQ-028 rst=1 at a rising edge: state ACCUM, pipeline valids 0, acc 0, count 0; out_valid=0, out_sum=0, out_count=0, out_ovf=0.
REQ-029 Reset mid-frame or in HOLD discards all partial and pending results; no result emitted for that frame.
REQ-030 in_ready=1 in first cycle after rst deasserts.

Structure
REQ-031 Shared package holds FSM state enum (ACCUM, DRAIN, HOLD), WIDTH/ACC_W defaults, count width constant 7.
REQ-032 One sub-module: signed_parallel_multiplier_9_PPA_Kogge_Stone instance with width=WIDTH, ports A, B, S; no behavioural multiply elsewhere.

Verification
REQ-033 Frame (3,4),(-5,6),(7,-8),last -> out_sum=-74, out_count=3, out_ovf=0, out_valid 3 edges after last acceptance.
REQ-034 Single beat (-256,-256), last -> out_sum=65536, out_count=1.
REQ-035 128 beats (-256,-256), last on 128th -> out_sum=-8388608 (wrapped), out_ovf=1, out_count=127.
REQ-036 Result held with out_ready=0 for 5 cycles -> in_ready=0, out_sum unchanged; out_ready=1 -> handshake, next frame accepted following cycle.
REQ-037 rst asserted after 2 beats of a frame -> all outputs 0; new frame (2,2),last -> out_sum=4, out_count=1.
REQ-038 200 random frames of 1-20 beats vs golden sum of 18-bit signed A*B products -> 100% match.
